// File: rtl/sdpb_fifo_ctrl.sv
// FWFT stream FIFO driving an SDPB block RAM; 3-cycle empty-to-m_valid latency, 1 word/cycle each way.
// s_ready drops only when the RAM itself is full; m_valid/m_ready stalls are absorbed by a 2-entry output buffer.
module sdpb_fifo_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W+1:0] level,
  output logic              RAM_CEA,
  output logic              RAM_WRE,
  output logic [13:0]       RAM_ADA,
  output logic [DATA_W-1:0] RAM_DI,
  output logic              RAM_CEB,
  output logic [13:0]       RAM_ADB,
  output logic              RAM_OCE,
  input  logic [DATA_W-1:0] RAM_DO
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   ram_cnt, ram_cnt_nx;
  logic              inflight;
  logic [1:0]        buf_cnt, buf_cnt_nx, slot;
  logic [DATA_W-1:0] buf0, buf1;
  logic [ADDR_W+1:0] level_q, level_nx;
  logic              push, pop, issue;
  logic [2:0]        pending;

  assign s_ready = !RESET && (ram_cnt != CNT_FULL);
  assign push    = s_valid && s_ready;
  assign m_valid = !RESET && (buf_cnt != 2'd0);
  assign pop     = m_valid && m_ready;

  // Buffer entries that will be occupied next cycle before any new issue lands.
  assign pending = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
  assign issue   = !RESET && (ram_cnt != '0) && (pending < 3'd2);
  assign slot    = buf_cnt - 2'(pop);

  always_comb begin
    ram_cnt_nx = ram_cnt;
    if (push && !issue) begin
      ram_cnt_nx = ram_cnt + CNT_ONE;
    end else if (!push && issue) begin
      ram_cnt_nx = ram_cnt - CNT_ONE;
    end
    buf_cnt_nx = pending[1:0];
    level_nx   = (ADDR_W + 2)'(ram_cnt_nx) + (ADDR_W + 2)'(issue) + (ADDR_W + 2)'(buf_cnt_nx);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      buf_cnt  <= '0;
      level_q  <= '0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (issue) rptr <= rptr + PTR_ONE;
      ram_cnt  <= ram_cnt_nx;
      inflight <= issue;
      buf_cnt  <= buf_cnt_nx;
      level_q  <= level_nx;
      if (pop && buf_cnt == 2'd2) buf0 <= buf1;
      // Returning read lands behind whatever survives this cycle's pop.
      if (inflight) begin
        if (slot == 2'd0) buf0 <= RAM_DO;
        else              buf1 <= RAM_DO;
      end
    end
  end

  assign m_data  = buf0;
  assign level   = RESET ? '0 : level_q;
  assign RAM_CEA = push;
  assign RAM_WRE = push;
  assign RAM_DI  = s_data;
  assign RAM_ADA = (14'(wptr) << (14 - ADDR_W)) | 14'h000F;
  assign RAM_CEB = issue;
  assign RAM_ADB = (14'(rptr) << (14 - ADDR_W)) | 14'h000F;
  assign RAM_OCE = 1'b1;

endmodule

// File: tb/tb_sdpb_fifo_ctrl.sv
// Bench for sdpb_fifo_ctrl: queue-based occupancy model checked every cycle plus directed literal checks.
module tb_sdpb_fifo_ctrl;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  logic        CLK, RESET;
  logic [31:0] s_data, m_data, RAM_DI, RAM_DO;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [10:0] level;
  logic        RAM_CEA, RAM_WRE, RAM_CEB, RAM_OCE;
  logic [13:0] RAM_ADA, RAM_ADB;

  int total = 0;
  int bad   = 0;

  sdpb_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
    .RAM_CEA(RAM_CEA), .RAM_WRE(RAM_WRE), .RAM_ADA(RAM_ADA), .RAM_DI(RAM_DI),
    .RAM_CEB(RAM_CEB), .RAM_ADB(RAM_ADB), .RAM_OCE(RAM_OCE), .RAM_DO(RAM_DO)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // SDPB primitive, bypass read mode: data out one cycle after the read enable edge.
  logic [31:0] mem [0:DEPTH-1];
  initial RAM_DO = 32'h0;
  always @(posedge CLK) begin
    if (RAM_CEA && RAM_WRE) mem[RAM_ADA[13:5]] <= RAM_DI;
    if (RAM_CEB) RAM_DO <= mem[RAM_ADB[13:5]];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int addr_of(input int p);
    return p * 32 + 15;
  endfunction

  // Reference model: words sit in RAM, one read slot, then the output buffer.
  logic [31:0] ram_q[$];
  logic [31:0] buf_q[$];
  logic [31:0] infl_d;
  int          infl = 0;
  int          wcnt = 0;
  int          rcnt = 0;

  initial begin
    bit r, e_sr, e_mv, d_push, d_pop, d_iss;
    int e_lvl;
    logic [31:0] sd;
    forever begin
      @(negedge CLK);
      r      = RESET;
      sd     = s_data;
      e_sr   = !r && ram_q.size() != DEPTH;
      e_mv   = !r && buf_q.size() != 0;
      e_lvl  = r ? 0 : ram_q.size() + infl + buf_q.size();
      d_push = s_valid && e_sr;
      d_pop  = e_mv && m_ready;
      d_iss  = !r && ram_q.size() != 0 && (buf_q.size() + infl - (d_pop ? 1 : 0)) < 2;
      chk("s_ready", s_ready, e_sr);
      chk("m_valid", m_valid, e_mv);
      chk("level", level, e_lvl);
      chk("ram_cea", RAM_CEA, d_push);
      chk("ram_wre", RAM_WRE, d_push);
      chk("ram_ceb", RAM_CEB, d_iss);
      chk("ram_oce", RAM_OCE, 1'b1);
      if (e_mv) chk("m_data", m_data, buf_q[0]);
      if (d_push) chk("ram_ada", RAM_ADA, addr_of(wcnt));
      if (d_iss) chk("ram_adb", RAM_ADB, addr_of(rcnt));
      @(posedge CLK);
      if (r) begin
        ram_q.delete();
        buf_q.delete();
        infl = 0;
        wcnt = 0;
        rcnt = 0;
      end else begin
        if (d_pop) void'(buf_q.pop_front());
        if (infl != 0) buf_q.push_back(infl_d);
        if (d_push) begin
          ram_q.push_back(sd);
          wcnt = (wcnt + 1) % DEPTH;
        end
        if (d_iss) begin
          infl_d = ram_q.pop_front();
          rcnt = (rcnt + 1) % DEPTH;
        end
        infl = d_iss ? 1 : 0;
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] d, input logic r);
    @(posedge CLK);
    #1;
    s_valid = v;
    s_data  = d;
    m_ready = r;
  endtask

  initial begin
    int acc, pops, first_pop, last_pop, maxlvl, n;
    bit found;
    RESET = 1'b1; s_valid = 1'b1; s_data = 32'hA5A5A5A5; m_ready = 1'b0;

    // Reset held 3 cycles with a pending producer
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rst_s_ready", s_ready, 1'b0);
      chk("rst_level", level, 0);
      chk("rst_cea", RAM_CEA, 1'b0);
      chk("rst_ceb", RAM_CEB, 1'b0);
      @(posedge CLK);
    end
    #1; RESET = 1'b0; s_valid = 1'b0;
    @(negedge CLK);
    chk("post_rst_s_ready", s_ready, 1'b1);

    // Single word latency
    cyc(1'b1, 32'hDEADBEEF, 1'b1);
    @(negedge CLK); chk("sw_c0_cea", RAM_CEA, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    @(negedge CLK); chk("sw_c1_ceb", RAM_CEB, 1'b1); chk("sw_c1_adb", RAM_ADB, 14'h000F); chk("sw_c1_lvl", level, 1);
    cyc(1'b0, 32'h0, 1'b1);
    @(negedge CLK); chk("sw_c2_mv", m_valid, 1'b0); chk("sw_c2_lvl", level, 1);
    cyc(1'b0, 32'h0, 1'b1);
    @(negedge CLK); chk("sw_c3_mv", m_valid, 1'b1); chk("sw_c3_data", m_data, 32'hDEADBEEF); chk("sw_c3_lvl", level, 1);
    cyc(1'b0, 32'h0, 1'b1);
    @(negedge CLK); chk("sw_c4_mv", m_valid, 1'b0); chk("sw_c4_lvl", level, 0);

    // Fill with consumer stalled
    acc = 0;
    for (int i = 0; i < 600; i++) begin
      cyc(1'b1, acc, 1'b0);
      @(negedge CLK);
      if (s_ready) acc++;
    end
    cyc(1'b0, 32'h0, 1'b0);
    @(negedge CLK);
    chk("fill_count", acc, 514);
    chk("fill_s_ready", s_ready, 1'b0);
    chk("fill_level", level, 514);
    for (int i = 0; i < 514; i++) begin
      cyc(1'b0, 32'h0, 1'b1);
      @(negedge CLK);
      chk("drain_word", {m_valid, m_data}, {1'b1, 32'(i)});
    end

    // Continuous streaming through several pointer wraps
    acc = 0; pops = 0; first_pop = -1; last_pop = -1;
    for (int c = 0; c < 3000 && pops < 2000; c++) begin
      cyc(acc < 2000, 32'h1000_0000 + acc, 1'b1);
      @(negedge CLK);
      if (s_valid && s_ready) acc++;
      if (m_valid && m_ready) begin
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        pops++;
      end
    end
    chk("stream_pops", pops, 2000);
    chk("stream_rate", last_pop - first_pop, 1999);

    // Random backpressure
    acc = 0; pops = 0; maxlvl = 0;
    for (int c = 0; c < 60000 && acc < 10000; c++) begin
      cyc($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 9) < 3);
      @(negedge CLK);
      if (s_valid && s_ready) acc++;
      if (m_valid && m_ready) pops++;
      if (int'(level) > maxlvl) maxlvl = int'(level);
    end
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      cyc(1'b0, 32'h0, 1'b1);
      @(negedge CLK);
      if (m_valid && m_ready) pops++;
      if (!m_valid && level == 0) found = 1'b1;
    end
    chk("rand_pushed", acc, 10000);
    chk("rand_popped", pops, 10000);
    chk("rand_max_level", maxlvl <= 514, 1'b1);
    chk("rand_drained", found, 1'b1);

    // Reset with 100 words held and a read in flight
    acc = 0;
    for (int c = 0; c < 400 && acc < 101; c++) begin
      cyc(1'b1, 32'hBAD0_0000 + acc, 1'b0);
      @(negedge CLK);
      if (s_ready) acc++;
    end
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1);
    @(negedge CLK); chk("mr_issue", RAM_CEB, 1'b1);
    @(posedge CLK); #1;
    chk("mr_level_before", level, 100);
    RESET = 1'b1; m_ready = 1'b0;
    @(negedge CLK); chk("mr_rst_level", level, 0); chk("mr_rst_mv", m_valid, 1'b0);
    @(posedge CLK); #1; RESET = 1'b0;
    @(negedge CLK); chk("mr_after_level", level, 0); chk("mr_after_mv", m_valid, 1'b0);
    cyc(1'b1, 32'h12345678, 1'b1);
    found = 1'b0; n = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (c > 0) cyc(1'b0, 32'h0, 1'b1);
      @(negedge CLK);
      if (m_valid) begin
        found = 1'b1;
        n = c;
        chk("mr_first_word", m_data, 32'h12345678);
      end
    end
    chk("mr_found", found, 1'b1);
    chk("mr_latency", n, 3);
    cyc(1'b0, 32'h0, 1'b1);
    @(negedge CLK); chk("mr_empty", m_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
